// File: rtl/serial_subtractor.sv
// Bit-serial recovery of x = sm - y - cin, one full-subtractor step per cycle, LSB first.
// Valid/ready on both sides; err flags a result outside [0, 2^W-1], x_zero flags x == 0.
module serial_subtractor #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   sm,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x,
  output logic         err,
  output logic         x_zero
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic [W:0]    sm_q;
  logic [W-1:0]  y_q;
  logic          cin_q;
  logic          b_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    diff_q;

  logic [W:0]    y_ext;
  logic          last_bit;
  logic          s_bit;
  logic          y_bit;
  logic          b_cur;
  logic          d_bit;
  logic          b_nxt;

  // Current bit slice: the carry-in stands in for the borrow on bit 0.
  assign y_ext    = {1'b0, y_q};
  assign last_bit = (cnt_q == CW'(W));
  assign s_bit    = sm_q[cnt_q];
  assign y_bit    = y_ext[cnt_q];
  assign b_cur    = (cnt_q == '0) ? cin_q : b_q;
  assign d_bit    = s_bit ^ y_bit ^ b_cur;
  assign b_nxt    = (~s_bit & (y_bit | b_cur)) | (y_bit & b_cur & s_bit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, serial datapath and result load.
  always_ff @(posedge clk) begin
    if (rst) begin
      sm_q   <= '0;
      y_q    <= '0;
      cin_q  <= 1'b0;
      b_q    <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      x      <= '0;
      err    <= 1'b0;
      x_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sm_q  <= sm;
            y_q   <= y;
            cin_q <= cin;
            b_q   <= 1'b0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          diff_q[cnt_q] <= d_bit;
          b_q           <= b_nxt;
          cnt_q         <= cnt_q + CW'(1);
          // Bit W has no register slot yet, so the flags use its live value.
          if (last_bit) begin
            x      <= diff_q[W-1:0];
            err    <= b_nxt | d_bit;
            x_zero <= (diff_q[W-1:0] == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor against an integer-arithmetic model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;
  localparam int unsigned LAT = W + 1;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W:0]   sm;
  logic [W-1:0] y;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] x;
  logic         err;
  logic         x_zero;

  int n_checks;
  int n_errors;

  serial_subtractor #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sm        (sm),
    .y         (y),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .err       (err),
    .x_zero    (x_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain signed arithmetic, then range test and truncation.
  task automatic model(input logic [W:0] s, input logic [W-1:0] yy, input logic c,
                       output logic [W-1:0] ex, output logic ee, output logic ez);
    int          full;
    logic [31:0] fv;
    full = int'(s) - int'(yy) - int'(c);
    fv   = full;
    ee   = (full < 0) || (full > (2 ** W) - 1);
    ex   = fv[W-1:0];
    ez   = (ex == '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_x"},         32'(x),         32'd0);
    check({tag, "_err"},       32'(err),       32'd0);
    check({tag, "_x_zero"},    32'(x_zero),    32'd0);
  endtask

  // One full transaction; assumes the DUT is IDLE and we are just past an edge.
  task automatic do_op(input logic [W:0] s, input logic [W-1:0] yy, input logic c,
                       input int hold, input bit scramble);
    logic [W-1:0] ex;
    logic         ee;
    logic         ez;
    int           lat;
    model(s, yy, c, ex, ee, ez);
    sm        = s;
    y         = yy;
    cin       = c;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    check("accept_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("run_in_ready", 32'(in_ready), 32'd0);
    lat = 0;
    for (int i = 1; i <= LAT + 4; i++) begin
      if (scramble) begin
        in_valid  = 1'($urandom);
        sm        = (W+1)'($urandom);
        y         = W'($urandom);
        cin       = 1'($urandom);
        out_ready = 1'($urandom);
      end
      tick();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    out_ready = 1'b0;
    check("latency", 32'(lat), 32'(LAT));
    check("x",       32'(x),      32'(ex));
    check("err",     32'(err),    32'(ee));
    check("x_zero",  32'(x_zero), 32'(ez));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      sm       = (W+1)'($urandom);
      tick();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready",  32'(in_ready),  32'd0);
      check("hold_x",         32'(x),         32'(ex));
      check("hold_err",       32'(err),       32'(ee));
      check("hold_x_zero",    32'(x_zero),    32'(ez));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1;
    check("done_no_in_ready", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready",  32'(in_ready),  32'd1);
    check("release_x_kept",    32'(x),         32'(ex));
    check("release_err_kept",  32'(err),       32'(ee));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    sm        = '0;
    y         = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();

    do_op(9'h047, 8'h34, 1'b1, 0, 1'b0);
    do_op(9'h1FE, 8'hFF, 1'b0, 1, 1'b0);
    do_op(9'h001, 8'h00, 1'b1, 0, 1'b0);
    do_op(9'h005, 8'h10, 1'b0, 2, 1'b0);
    do_op(9'h1FF, 8'h00, 1'b0, 0, 1'b0);
    do_op(9'h100, 8'h00, 1'b0, 0, 1'b0);
    do_op(9'h047, 8'h34, 1'b1, 5, 1'b1);
    do_op(9'h000, 8'h00, 1'b1, 0, 1'b1);
    do_op(9'h0FF, 8'h00, 1'b0, 0, 1'b1);

    // Abort during RUN after bits 0..3, with a handshake attempt on the reset edge.
    sm       = 9'h047;
    y        = 8'h34;
    cin      = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    check_reset_state("abort_run");
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      check("abort_no_pulse", 32'(out_valid), 32'd0);
    end
    do_op(9'h047, 8'h34, 1'b1, 0, 1'b0);

    // Abort while holding a result in DONE.
    sm       = 9'h1FF;
    y        = 8'h01;
    cin      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < LAT + 1; i++) tick();
    check("pre_abort_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("abort_done");

    for (int n = 0; n < 40; n++) begin
      logic [W:0]   rs;
      logic [W-1:0] ry;
      rs = (W+1)'($urandom);
      ry = W'($urandom);
      if (n % 4 == 1) ry = W'(rs[W-1:0] - W'($urandom_range(0, 2)));
      do_op(rs, ry, 1'($urandom), int'($urandom_range(0, 3)), 1'(n % 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter W, default 8, operand width; the sum input is W+1 bits wide.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  block accepts a request.
REQ-006 sm  input  W+1  sum to be decomposed.
REQ-007 y  input  W  known operand.
REQ-008 cin  input  1  carry-in used to form sm.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 x  output  W  recovered operand, x = sm - y - cin.
REQ-012 err  output  1  recovered operand not representable in W bits.
REQ-013 x_zero  output  1  x == 0.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 Accept: in IDLE with in_valid=1, the block SHALL capture sm, y and cin into internal registers and go to RUN. It SHALL clear the borrow register and the bit counter on that edge.
REQ-017 RUN, one bit per cycle, LSB first: each edge SHALL compute diff bit i = sm[i] ^ y[i] ^ b, where y[W] is 0 and b is the borrow (for i=0, b = cin).
REQ-018 On the same edge, the borrow SHALL update to (~sm[i] & (y[i] | b)) | (y[i] & b & sm[i]), i.e. the standard full-subtractor borrow.
REQ-019 RUN SHALL last exactly W+1 edges covering bits 0..W; the W+1th edge SHALL load x, err and x_zero and go to DONE.
REQ-020 Latency: if accept happens at edge k, out_valid SHALL first be high after edge k+W+1 (W=8: 9 edges).
REQ-021 err SHALL be 1 when the final borrow is 1 (underflow, sm < y+cin) or when diff bit W is 1 with no final borrow (overflow, result > 2^W-1).
REQ-022 x SHALL be diff bits W-1..0, i.e. the result modulo 2^W, even when err=1.
REQ-023 x_zero SHALL be 1 iff x == 0, regardless of err.
REQ-024 DONE: the block SHALL hold out_valid and keep x, err and x_zero stable until out_ready=1. At that edge it SHALL return to IDLE.
REQ-025 A result and a new request SHALL NOT be transferred in the same cycle; in_ready stays 0 in DONE even when out_ready=1.
REQ-026 in_valid, sm, y and cin SHALL be ignored outside IDLE; changing them during RUN SHALL NOT affect the result.
REQ-027 x, err and x_zero SHALL keep their last values after leaving DONE, until the next result is loaded.
REQ-028 out_ready SHALL be ignored outside DONE.

Reset
REQ-029 With rst=1 at an edge, the block SHALL go to IDLE and force out_valid=0, x=0, err=0 and x_zero=0, and in_ready SHALL read 1.
REQ-030 Reset asserted during RUN or DONE SHALL abort the operation with no out_valid pulse. The pending result is discarded.
REQ-031 Reset SHALL take priority over any simultaneous handshake.

Verification (W=8)
REQ-032 Basic: sm=0x047, y=0x34, cin=1 -> x=0x12, err=0, x_zero=0; out_valid rises exactly 9 edges after accept.
REQ-033 Max operands: sm=0x1FE, y=0xFF, cin=0 -> x=0xFF, err=0. Zero result: sm=0x001, y=0x00, cin=1 -> x=0x00, x_zero=1, err=0.
REQ-034 Underflow: sm=0x005, y=0x10, cin=0 -> err=1, x=0xF5, x_zero=0.
REQ-035 Overflow: sm=0x1FF, y=0x00, cin=0 -> err=1, x=0xFF. Also sm=0x100, y=0, cin=0 -> err=1, x=0x00, x_zero=1.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, x, err and x_zero are stable and in_ready=0. Toggling in_valid and sm during RUN does not change the result.
REQ-037 Reset mid-RUN at bit 4 -> after the next edge out_valid=0, in_ready=1 and x=0. A following request with sm=0x047, y=0x34, cin=1 completes correctly with x=0x12.
